// File: rtl/kf8255_bus_master.sv
// Host-side bus master for an 8255 PPI: turns single commands into timed
// chip-select / address / strobe sequences and composes control words.
module kf8255_bus_master #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_kind,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       chip_select_n,
    output logic       read_enable_n,
    output logic       write_enable_n,
    output logic [1:0] address,
    output logic [7:0] data_bus_out,
    output logic       data_bus_out_enable,
    input  logic [7:0] data_bus_in
);

    localparam logic [1:0] KindRawWrite = 2'd0;
    localparam logic [1:0] KindRawRead  = 2'd1;
    localparam logic [1:0] KindModeSet  = 2'd2;
    localparam logic [1:0] KindBitSr    = 2'd3;
    localparam logic [1:0] AddrControl  = 2'd3;

    localparam logic [3:0] SetupLast = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] PulseLast = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] HoldLast  = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       is_read_q;
    logic [1:0] addr_q;
    logic [7:0] wdata_q;
    logic       done_q;
    logic [7:0] rd_data_q;

    logic       accept;
    logic       hold_end;
    logic       capture;
    logic [1:0] cmd_addr_c;
    logic [7:0] cmd_wdata_c;

    // Control words are composed at accept time so the bus phase only
    // replays latched values.
    always_comb begin
        cmd_addr_c  = cmd_addr;
        cmd_wdata_c = cmd_data;
        case (cmd_kind)
            KindModeSet: begin
                cmd_addr_c  = AddrControl;
                cmd_wdata_c = {1'b1, cmd_data[6:0]};
            end
            KindBitSr: begin
                cmd_addr_c  = AddrControl;
                cmd_wdata_c = {4'b0000, cmd_data[3:0]};
            end
            default: begin
                cmd_addr_c  = cmd_addr;
                cmd_wdata_c = cmd_data;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        hold_end = 1'b0;
        capture  = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = StSetup;
                    cnt_d   = 4'd0;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    state_d = StStrobe;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StStrobe: begin
                if (cnt_q == PulseLast) begin
                    state_d = StHold;
                    cnt_d   = 4'd0;
                    capture = is_read_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d  = StIdle;
                    cnt_d    = 4'd0;
                    hold_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            is_read_q <= 1'b0;
            addr_q    <= 2'd0;
            wdata_q   <= 8'd0;
            done_q    <= 1'b0;
            rd_data_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= hold_end;
            if (accept) begin
                is_read_q <= (cmd_kind == KindRawRead);
                addr_q    <= cmd_addr_c;
                wdata_q   <= cmd_wdata_c;
            end
            if (capture) begin
                rd_data_q <= data_bus_in;
            end
        end
    end

    // Bus outputs decode straight from state so reset idles the bus at once.
    logic busy;
    logic drive;
    always_comb begin
        busy                = (state_q != StIdle);
        drive               = busy && !is_read_q;
        cmd_ready           = !busy;
        chip_select_n       = !busy;
        address             = busy ? addr_q : 2'd0;
        data_bus_out_enable = drive;
        data_bus_out        = drive ? wdata_q : 8'd0;
        write_enable_n      = !((state_q == StStrobe) && !is_read_q);
        read_enable_n       = !((state_q == StStrobe) && is_read_q);
        done                = done_q;
        rd_data             = rd_data_q;
    end

    logic unused_kind;
    assign unused_kind = (cmd_kind == KindRawWrite);

endmodule
